rle_encoder: RTL and testbench
==============================

# rle_encoder

Parametrised run-length encoder for a symbol stream. It accepts one symbol per cycle over a valid/ready handshake and emits (symbol, run length) pairs over a second valid/ready handshake. Runs longer than the count field can hold are split rather than wrapped. An explicit flush request closes the open run at end of stream. The block sits between the symbol source and the packer, as the generalised replacement for the fixed four-letter run counter.

## Interface
- DW, 8: symbol width in bits.
- CW, 3: run-count width in bits, CW ≥ 1. MAXRUN = 2^CW − 1.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  source has a symbol on IN_DATA.
- IN_READY  out  1  block accepts the symbol this cycle (combinational).
- IN_DATA  in  DW  input symbol.
- FLUSH  in  1  level request to emit the open run as the final pair.
- OUT_VALID  out  1  the output pair is valid.
- OUT_READY  in  1  sink takes the pair this cycle.
- OUT_DATA  out  DW  symbol of the emitted run.
- OUT_COUNT  out  CW  run length, always in the range 1..MAXRUN.
- OUT_LAST  out  1  the pair was produced by FLUSH.
- RUN_ACTIVE  out  1  a run is open (state RUN).

## Operation
- Internal state:
  - state: IDLE or RUN.
  - SYM[DW]: symbol of the open run.
  - CNT[CW]: length of the open run; 1..MAXRUN in RUN, 0 in IDLE.
  - Output register: OUT_DATA / OUT_COUNT / OUT_LAST / OUT_VALID.
- Slot free: SLOT = !OUT_VALID || OUT_READY.
- IN_READY = SLOT && !(FLUSH && state==RUN).
- Accept: IN_VALID && IN_READY.
- On accept of symbol s:
  - IDLE: SYM←s, CNT←1, go to RUN. No emit.
  - RUN, s==SYM, CNT<MAXRUN: CNT←CNT+1. No emit.
  - RUN, s==SYM, CNT==MAXRUN: emit (SYM, MAXRUN, LAST=0), then CNT←1 and stay in RUN with the same symbol.
  - RUN, s≠SYM: emit (SYM, CNT, LAST=0), then SYM←s, CNT←1.
- Flush: when FLUSH && state==RUN && SLOT:
  - emit (SYM, CNT, LAST=1), CNT←0, go to IDLE.
  - FLUSH has priority over input, because IN_READY is forced low in that case.
- FLUSH in IDLE: no effect.
- FLUSH is a level signal. It is held by the source until RUN_ACTIVE falls, and it stalls while SLOT=0.
- Emit: loads the output register and sets OUT_VALID=1.
- OUT_VALID clears when OUT_READY=1 and there is no new emit in the same cycle.
- A new emit on the same cycle as the sink taking the old pair overwrites the register: back-to-back, no bubble.
- While OUT_VALID && !OUT_READY, all output fields hold stable and IN_READY=0.
- CNT never wraps. A count of 0 is never emitted.

## Timing
- Reset (RST low, asynchronous):
  - state=IDLE, SYM=0, CNT=0.
  - OUT_VALID=0, OUT_DATA=0, OUT_COUNT=0, OUT_LAST=0, RUN_ACTIVE=0.
  - IN_READY=1 once RST is released, provided FLUSH is low.
- Reset mid-run discards the open run and any undelivered output pair. No pair is emitted for it.
- Latency: OUT_VALID rises on the clock edge that accepts the terminating symbol, or that samples the flush. The pair is visible in the following cycle.
- Throughput: one symbol per cycle while OUT_READY=1, including cycles with back-to-back emits.
- IN_READY depends combinationally on OUT_READY, FLUSH and state. IN_VALID and IN_DATA have no combinational path to any output.
- OUT_VALID, once high, stays high until a cycle with OUT_READY=1. The source may not retract a pair.

## Test plan
- DW=8, CW=3: input 97,97,97,98 then FLUSH → (97,3,LAST=0), then (98,1,LAST=1); RUN_ACTIVE=0 afterwards.
- DW=8, CW=3: nine consecutive 99, then FLUSH → (99,7,0), then (99,2,1); OUT_COUNT never shows 0 or a wrapped value.
- Backpressure: hold OUT_READY=0 after (97,2,0) is emitted → IN_READY=0, the output holds (97,2,0) for 5 cycles, no input is lost; release OUT_READY → the stream resumes at one symbol per cycle.
- Simultaneous FLUSH and IN_VALID=1 (symbol 100) in RUN → symbol not accepted, the flush pair is emitted; the next cycle accepts 100 and opens a new run. FLUSH in IDLE → no output.
- Assert RST low mid-run with OUT_VALID=1 → all outputs become 0 immediately (asynchronous); after release, the input 5,5 then FLUSH yields only (5,2,1).
- DW=16, CW=1: input 0x1234,0x1234,0xBEEF then FLUSH → (0x1234,1,0), (0x1234,1,0), (0xBEEF,1,1).

Source files
------------

// File: rtl/rle_encoder_if.sv
// Symbol-in / (symbol, run length)-out stream bundle for the run-length encoder.
// The encoder takes the slave view; the symbol source and pair sink share the master view.
interface rle_encoder_if #(
    parameter int DW = 8,
    parameter int CW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_last;
    logic          run_active;

    modport slave (
        input  in_valid,
        input  in_data,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count,
        output out_last,
        output run_active
    );

    modport master (
        output in_valid,
        output in_data,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_last,
        input  run_active
    );
endinterface

// File: rtl/rle_encoder.sv
// Run-length encoder: folds a valid/ready symbol stream into (symbol, count) pairs,
// splitting runs at the count ceiling and closing the open run on a flush request.
module rle_encoder #(
    parameter int DW = 8,
    parameter int CW = 3
) (
    input logic         clk,
    input logic         rst_n,
    rle_encoder_if.slave bus
);
    localparam logic [CW-1:0] MAXRUN = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_p0, state_nxt;
    logic [DW-1:0] sym_p0,   sym_nxt;
    logic [CW-1:0] cnt_p0,   cnt_nxt;

    logic          vld_p1,       vld_nxt;
    logic [DW-1:0] pair_sym_p1,  pair_sym_nxt;
    logic [CW-1:0] pair_cnt_p1,  pair_cnt_nxt;
    logic          pair_last_p1, pair_last_nxt;

    logic slot;
    logic flush_hold;
    logic flush_go;
    logic accept;

    // A full run cannot grow; the next matching symbol forces a split instead of a wrap.
    function automatic logic run_full(input logic [CW-1:0] cnt);
        return cnt == MAXRUN;
    endfunction

    function automatic logic [CW-1:0] run_inc(input logic [CW-1:0] cnt);
        return run_full(cnt) ? MAXRUN : cnt + CW'(1);
    endfunction

    assign slot       = !vld_p1 || bus.out_ready;
    assign flush_hold = bus.flush && (state_p0 == RUN);
    assign flush_go   = flush_hold && slot;
    assign accept     = bus.in_valid && bus.in_ready;

    assign bus.in_ready   = slot && !flush_hold;
    assign bus.run_active = (state_p0 == RUN);
    assign bus.out_valid  = vld_p1;
    assign bus.out_data   = pair_sym_p1;
    assign bus.out_count  = pair_cnt_p1;
    assign bus.out_last   = pair_last_p1;

    always_comb begin
        state_nxt     = state_p0;
        sym_nxt       = sym_p0;
        cnt_nxt       = cnt_p0;
        vld_nxt       = vld_p1 && !bus.out_ready;
        pair_sym_nxt  = pair_sym_p1;
        pair_cnt_nxt  = pair_cnt_p1;
        pair_last_nxt = pair_last_p1;

        if (flush_go) begin
            vld_nxt       = 1'b1;
            pair_sym_nxt  = sym_p0;
            pair_cnt_nxt  = cnt_p0;
            pair_last_nxt = 1'b1;
            cnt_nxt       = '0;
            state_nxt     = IDLE;
        end else if (accept) begin
            unique case (state_p0)
                IDLE: begin
                    sym_nxt   = bus.in_data;
                    cnt_nxt   = CW'(1);
                    state_nxt = RUN;
                end
                RUN: begin
                    if (bus.in_data == sym_p0 && !run_full(cnt_p0)) begin
                        cnt_nxt = run_inc(cnt_p0);
                    end else begin
                        vld_nxt       = 1'b1;
                        pair_sym_nxt  = sym_p0;
                        pair_cnt_nxt  = cnt_p0;
                        pair_last_nxt = 1'b0;
                        sym_nxt       = bus.in_data;
                        cnt_nxt       = CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Stage p0: open-run accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
            sym_p0   <= '0;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            sym_p0   <= sym_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

    // Stage p1: emitted pair register, overwritten in place when the sink drains it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            pair_sym_p1  <= '0;
            pair_cnt_p1  <= '0;
            pair_last_p1 <= 1'b0;
        end else begin
            vld_p1       <= vld_nxt;
            pair_sym_p1  <= pair_sym_nxt;
            pair_cnt_p1  <= pair_cnt_nxt;
            pair_last_p1 <= pair_last_nxt;
        end
    end
endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: DW=8/CW=3 instance for most scenarios, DW=16/CW=1 for splitting.
module tb_rle_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rle_encoder_if #(.DW(8),  .CW(3)) a_if ();
    rle_encoder_if #(.DW(16), .CW(1)) b_if ();

    rle_encoder #(.DW(8), .CW(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    rle_encoder #(.DW(16), .CW(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pair_a(input string tag, input logic [7:0] d, input logic [2:0] c,
                              input logic l);
        chk({tag, ".valid"}, 32'(a_if.out_valid), 32'd1);
        chk({tag, ".data"},  32'(a_if.out_data),  32'(d));
        chk({tag, ".count"}, 32'(a_if.out_count), 32'(c));
        chk({tag, ".last"},  32'(a_if.out_last),  32'(l));
    endtask

    task automatic chk_pair_b(input string tag, input logic [15:0] d, input logic l);
        chk({tag, ".valid"}, 32'(b_if.out_valid), 32'd1);
        chk({tag, ".data"},  32'(b_if.out_data),  32'(d));
        chk({tag, ".count"}, 32'(b_if.out_count), 32'd1);
        chk({tag, ".last"},  32'(b_if.out_last),  32'(l));
    endtask

    task automatic feed_a(input logic [7:0] d);
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        cyc();
    endtask

    initial begin
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.flush = 1'b0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.flush = 1'b0; b_if.out_ready = 1'b1;
        cyc();
        cyc();

        // reset state
        chk("rst.valid", 32'(a_if.out_valid),  32'd0);
        chk("rst.data",  32'(a_if.out_data),   32'd0);
        chk("rst.count", 32'(a_if.out_count),  32'd0);
        chk("rst.last",  32'(a_if.out_last),   32'd0);
        chk("rst.run",   32'(a_if.run_active), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(a_if.in_ready), 32'd1);

        // 97,97,97,98 + flush
        feed_a(8'd97);
        chk("t1.run_open", 32'(a_if.run_active), 32'd1);
        feed_a(8'd97);
        feed_a(8'd97);
        chk("t1.no_emit", 32'(a_if.out_valid), 32'd0);
        feed_a(8'd98);
        chk_pair_a("t1.p0", 8'd97, 3'd3, 1'b0);
        a_if.in_valid = 1'b0;
        a_if.flush    = 1'b1;
        #1;
        chk("t1.flush_blocks_in", 32'(a_if.in_ready), 32'd0);
        cyc();
        chk_pair_a("t1.p1", 8'd98, 3'd1, 1'b1);
        chk("t1.run_closed", 32'(a_if.run_active), 32'd0);
        a_if.flush = 1'b0;
        cyc();
        chk("t1.drained", 32'(a_if.out_valid), 32'd0);

        // nine 99s split at MAXRUN=7
        for (int i = 0; i < 9; i++) begin
            feed_a(8'd99);
            if (i == 7) chk_pair_a("t2.split", 8'd99, 3'd7, 1'b0);
            else        chk("t2.quiet", 32'(a_if.out_valid), 32'd0);
        end
        a_if.in_valid = 1'b0;
        a_if.flush    = 1'b1;
        cyc();
        chk_pair_a("t2.tail", 8'd99, 3'd2, 1'b1);
        a_if.flush = 1'b0;
        cyc();

        // backpressure holds the pair and stalls input
        feed_a(8'd97);
        feed_a(8'd97);
        feed_a(8'd98);
        chk_pair_a("t3.pair", 8'd97, 3'd2, 1'b0);
        a_if.out_ready = 1'b0;
        a_if.in_data   = 8'd98;
        #1;
        chk("t3.stall", 32'(a_if.in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_pair_a("t3.hold", 8'd97, 3'd2, 1'b0);
            chk("t3.hold_ready", 32'(a_if.in_ready), 32'd0);
        end
        a_if.out_ready = 1'b1;
        #1;
        chk("t3.release", 32'(a_if.in_ready), 32'd1);
        cyc();
        chk("t3.taken", 32'(a_if.out_valid), 32'd0);
        feed_a(8'd99);
        chk_pair_a("t3.resume", 8'd98, 3'd2, 1'b0);
        feed_a(8'd99);
        chk("t3.b2b_drain", 32'(a_if.out_valid), 32'd0);
        a_if.in_valid = 1'b0;
        a_if.flush    = 1'b1;
        cyc();
        chk_pair_a("t3.tail", 8'd99, 3'd2, 1'b1);
        a_if.flush = 1'b0;
        cyc();

        // flush beats a simultaneous symbol; flush in IDLE is inert
        feed_a(8'd50);
        feed_a(8'd50);
        a_if.in_data = 8'd100;
        a_if.flush   = 1'b1;
        #1;
        chk("t4.in_blocked", 32'(a_if.in_ready), 32'd0);
        cyc();
        chk_pair_a("t4.flush", 8'd50, 3'd2, 1'b1);
        a_if.flush = 1'b0;
        #1;
        chk("t4.idle", 32'(a_if.run_active), 32'd0);
        chk("t4.ready", 32'(a_if.in_ready), 32'd1);
        cyc();
        chk("t4.new_run", 32'(a_if.run_active), 32'd1);
        chk("t4.no_emit", 32'(a_if.out_valid), 32'd0);
        a_if.in_valid = 1'b0;
        a_if.flush    = 1'b1;
        cyc();
        chk_pair_a("t4.p100", 8'd100, 3'd1, 1'b1);
        cyc();
        chk("t4.idle_flush.valid", 32'(a_if.out_valid), 32'd0);
        cyc();
        chk("t4.idle_flush.valid2", 32'(a_if.out_valid), 32'd0);
        chk("t4.idle_flush.run", 32'(a_if.run_active), 32'd0);
        a_if.flush = 1'b0;
        cyc();

        // asynchronous reset mid-run with a pending pair
        feed_a(8'd7);
        feed_a(8'd7);
        feed_a(8'd8);
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b0;
        chk_pair_a("t5.pending", 8'd7, 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5.valid", 32'(a_if.out_valid),  32'd0);
        chk("t5.data",  32'(a_if.out_data),   32'd0);
        chk("t5.count", 32'(a_if.out_count),  32'd0);
        chk("t5.last",  32'(a_if.out_last),   32'd0);
        chk("t5.run",   32'(a_if.run_active), 32'd0);
        cyc();
        rst_n          = 1'b1;
        a_if.out_ready = 1'b1;
        feed_a(8'd5);
        feed_a(8'd5);
        chk("t5.no_stale", 32'(a_if.out_valid), 32'd0);
        a_if.in_valid = 1'b0;
        a_if.flush    = 1'b1;
        cyc();
        chk_pair_a("t5.only", 8'd5, 3'd2, 1'b1);
        a_if.flush = 1'b0;
        cyc();
        chk("t5.done", 32'(a_if.out_valid), 32'd0);

        // DW=16, CW=1: every repeat splits
        b_if.in_valid = 1'b1;
        b_if.in_data  = 16'h1234;
        cyc();
        chk("t6.first_quiet", 32'(b_if.out_valid), 32'd0);
        cyc();
        chk_pair_b("t6.p0", 16'h1234, 1'b0);
        b_if.in_data = 16'hBEEF;
        cyc();
        chk_pair_b("t6.p1", 16'h1234, 1'b0);
        b_if.in_valid = 1'b0;
        b_if.flush    = 1'b1;
        cyc();
        chk_pair_b("t6.p2", 16'hBEEF, 1'b1);
        b_if.flush = 1'b0;
        cyc();
        chk("t6.done", 32'(b_if.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
